pid_sequencer: RTL and testbench



---
 rtl/pid_pkg.sv | 45 ++++
 rtl/pid_sequencer_if.sv | 24 ++
 rtl/pid_mult.sv | 12 +
 rtl/pid_sequencer.sv | 119 +++++++++++
 tb/tb_pid_sequencer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pid_pkg.sv
// rtl/pid_pkg.sv - widths, FSM encoding and saturation helpers for the PID sequencer
package pid_pkg;

  localparam int W_IN   = 9;
  localparam int W_E    = 10;
  localparam int W_DE   = 11;
  localparam int W_I    = 16;
  localparam int W_OP   = 18;
  localparam int W_PROD = 27;
  localparam int W_OUT  = 18;
  localparam int W_U    = W_PROD + 2;

  localparam logic signed [W_I-1:0]   I_MAX   = 16'sh7fff;
  localparam logic signed [W_I-1:0]   I_MIN   = 16'sh8000;
  localparam logic signed [W_OUT-1:0] OUT_MAX = 18'sh1ffff;
  localparam logic signed [W_OUT-1:0] OUT_MIN = 18'sh20000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAP,
    S_MP,
    S_MI,
    S_MD,
    S_SUM
  } state_e;

  function automatic logic signed [W_I-1:0] sat16(input logic signed [W_I:0] x);
    if (x > (W_I+1)'(I_MAX))
      return I_MAX;
    else if (x < (W_I+1)'(I_MIN))
      return I_MIN;
    else
      return x[W_I-1:0];
  endfunction

  function automatic logic signed [W_OUT-1:0] sat18(input logic signed [W_U-1:0] x);
    if (x > W_U'(OUT_MAX))
      return OUT_MAX;
    else if (x < W_U'(OUT_MIN))
      return OUT_MIN;
    else
      return x[W_OUT-1:0];
  endfunction

endpackage

// File: rtl/pid_sequencer_if.sv
// rtl/pid_sequencer_if.sv - measurement/coefficient inputs and PWM command outputs of the sequencer
interface pid_sequencer_if;
  import pid_pkg::*;

  logic signed [W_IN-1:0]  yactual;
  logic signed [W_IN-1:0]  referencia;
  logic signed [W_IN-1:0]  kp;
  logic signed [W_IN-1:0]  ki;
  logic signed [W_IN-1:0]  kd;
  logic                    ena2;
  logic signed [W_OUT-1:0] PWMin;
  logic                    busy;

  modport master (
    output yactual, referencia, kp, ki, kd,
    input  ena2, PWMin, busy
  );

  modport slave (
    input  yactual, referencia, kp, ki, kd,
    output ena2, PWMin, busy
  );

endinterface

// File: rtl/pid_mult.sv
// rtl/pid_mult.sv - combinational signed 18x9 -> 27 multiplier shared by the P, I and D terms
module pid_mult
  import pid_pkg::*;
(
  input  logic signed [W_OP-1:0]   a,
  input  logic signed [W_IN-1:0]   b,
  output logic signed [W_PROD-1:0] p
);

  assign p = W_PROD'(a) * W_PROD'(b);

endmodule

// File: rtl/pid_sequencer.sv
// rtl/pid_sequencer.sv - sample-rate tick, P/I/D multiplier sequencing and saturated PWM command
module pid_sequencer
  import pid_pkg::*;
#(
  parameter int DIV   = 512,
  parameter int SHIFT = 0
) (
  input  logic           clk,
  input  logic           rst,
  pid_sequencer_if.slave bus
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     tick;
  state_e                   state_q, state_d;
  logic signed [W_E-1:0]    e_q, e_d, e_prev_q, e_prev_d, e_new;
  logic signed [W_DE-1:0]   de_q, de_d;
  logic signed [W_I-1:0]    integ_q, integ_d;
  logic signed [W_IN-1:0]   kp_q, kp_d, ki_q, ki_d, kd_q, kd_d;
  logic signed [W_PROD-1:0] pterm_q, pterm_d, iterm_q, iterm_d, dterm_q, dterm_d;
  logic signed [W_OUT-1:0]  pwm_q, pwm_d;
  logic signed [W_OP-1:0]   op_a;
  logic signed [W_IN-1:0]   op_b;
  logic signed [W_PROD-1:0] prod, prod_sh;
  logic signed [W_U-1:0]    u;

  assign tick    = (cnt_q == CW'(DIV - 1));
  assign e_new   = W_E'(bus.referencia) - W_E'(bus.yactual);
  assign prod_sh = prod >>> SHIFT;
  assign u       = W_U'(pterm_q) + W_U'(iterm_q) + W_U'(dterm_q);

  pid_mult u_mult (.a(op_a), .b(op_b), .p(prod));

  // Operand steering kept apart from the state logic so the product has no loop through it
  always_comb begin
    op_a = '0;
    op_b = '0;
    case (state_q)
      S_MP: begin op_a = W_OP'(e_q);     op_b = kp_q; end
      S_MI: begin op_a = W_OP'(integ_q); op_b = ki_q; end
      S_MD: begin op_a = W_OP'(de_q);    op_b = kd_q; end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    state_d  = state_q;
    e_d      = e_q;
    e_prev_d = e_prev_q;
    de_d     = de_q;
    integ_d  = integ_q;
    kp_d     = kp_q;
    ki_d     = ki_q;
    kd_d     = kd_q;
    pterm_d  = pterm_q;
    iterm_d  = iterm_q;
    dterm_d  = dterm_q;
    pwm_d    = pwm_q;
    case (state_q)
      S_IDLE: if (tick) state_d = S_CAP;
      S_CAP: begin
        e_d      = e_new;
        de_d     = W_DE'(e_new) - W_DE'(e_prev_q);
        e_prev_d = e_new;
        integ_d  = sat16((W_I+1)'(integ_q) + (W_I+1)'(e_new));
        kp_d     = bus.kp;
        ki_d     = bus.ki;
        kd_d     = bus.kd;
        state_d  = S_MP;
      end
      S_MP: begin pterm_d = prod_sh; state_d = S_MI; end
      S_MI: begin iterm_d = prod_sh; state_d = S_MD; end
      S_MD: begin dterm_d = prod_sh; state_d = S_SUM; end
      S_SUM: begin pwm_d = sat18(u); state_d = S_IDLE; end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      state_q  <= S_IDLE;
      e_q      <= '0;
      e_prev_q <= '0;
      de_q     <= '0;
      integ_q  <= '0;
      kp_q     <= '0;
      ki_q     <= '0;
      kd_q     <= '0;
      pterm_q  <= '0;
      iterm_q  <= '0;
      dterm_q  <= '0;
      pwm_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      e_q      <= e_d;
      e_prev_q <= e_prev_d;
      de_q     <= de_d;
      integ_q  <= integ_d;
      kp_q     <= kp_d;
      ki_q     <= ki_d;
      kd_q     <= kd_d;
      pterm_q  <= pterm_d;
      iterm_q  <= iterm_d;
      dterm_q  <= dterm_d;
      pwm_q    <= pwm_d;
    end
  end

  // The new command is presented in the SUM cycle itself, alongside ena2
  assign bus.ena2  = (state_q == S_SUM);
  assign bus.busy  = (state_q != S_IDLE);
  assign bus.PWMin = (state_q == S_SUM) ? pwm_d : pwm_q;

endmodule

// File: tb/tb_pid_sequencer.sv
// tb/tb_pid_sequencer.sv - randomized and directed bench for pid_sequencer against a per-sample model
module tb_pid_sequencer;

  localparam int DIV   = 16;
  localparam int SHIFT = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pid_sequencer_if bus();

  pid_sequencer #(.DIV(DIV), .SHIFT(SHIFT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc;
  int last_ena;
  int s_ref, s_y, s_kp, s_ki, s_kd;
  longint m_eprev, m_integ, m_pwm;

  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;

  // Inputs as seen on the capture edge of each sample
  always @(posedge clk)
    if (rst && cyc != 0 && (cyc % DIV) == 0) begin
      s_ref <= int'(bus.referencia);
      s_y   <= int'(bus.yactual);
      s_kp  <= int'(bus.kp);
      s_ki  <= int'(bus.ki);
      s_kd  <= int'(bus.kd);
    end

  function automatic longint clampv(input longint x, input longint lo, input longint hi);
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  task automatic model_sample();
    longint e, de, u;
    e       = longint'(s_ref) - longint'(s_y);
    de      = e - m_eprev;
    m_eprev = e;
    m_integ = clampv(m_integ + e, -32768, 32767);
    u = ((e * s_kp) >>> SHIFT) + ((m_integ * s_ki) >>> SHIFT) + ((de * s_kd) >>> SHIFT);
    m_pwm = clampv(u, -131072, 131071);
  endtask

  task automatic set_in(input int r, input int y, input int p, input int i, input int d);
    bus.referencia = 9'(r);
    bus.yactual    = 9'(y);
    bus.kp         = 9'(p);
    bus.ki         = 9'(i);
    bus.kd         = 9'(d);
  endtask

  function automatic int rnd9();
    return int'($urandom_range(0, 511)) - 256;
  endfunction

  task automatic model_clear();
    m_eprev  = 0;
    m_integ  = 0;
    m_pwm    = 0;
    last_ena = -1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    model_clear();
    rst = 1'b1;
  endtask

  task automatic wait_phase(input int ph);
    int n = 0;
    while (!((cyc % DIV) == ph && cyc >= DIV) && n < 3 * DIV) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!((cyc % DIV) == ph && cyc >= DIV)) begin
      failures++;
      $display("FAIL phase_timeout got=%0d exp_phase=%0d", cyc, ph);
    end
  endtask

  task automatic wait_sample();
    int n = 0;
    while (bus.ena2 !== 1'b1 && n < 2 * DIV + 8) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.ena2 !== 1'b1) begin
      failures++;
      $display("FAIL ena2_timeout got=%0b exp=1", bus.ena2);
    end else begin
      model_sample();
      checks++;
      if (bus.PWMin !== 18'(m_pwm)) begin
        failures++;
        $display("FAIL pwmin got=%0d exp=%0d", bus.PWMin, m_pwm);
      end
      checks++;
      if ((cyc % DIV) != 4 || cyc < DIV + 4) begin
        failures++;
        $display("FAIL ena2_latency got_cycle=%0d exp_phase=4", cyc);
      end
      checks++;
      if (bus.busy !== 1'b1) begin
        failures++;
        $display("FAIL busy_in_sum got=%0b exp=1", bus.busy);
      end
      if (last_ena >= 0) begin
        checks++;
        if (cyc - last_ena != DIV) begin
          failures++;
          $display("FAIL ena2_period got=%0d exp=%0d", cyc - last_ena, DIV);
        end
      end
      last_ena = cyc;
      @(negedge clk);
      checks++;
      if (bus.ena2 !== 1'b0 || bus.busy !== 1'b0 || bus.PWMin !== 18'(m_pwm)) begin
        failures++;
        $display("FAIL after_sum got ena2=%0b busy=%0b pwm=%0d exp ena2=0 busy=0 pwm=%0d",
                 bus.ena2, bus.busy, bus.PWMin, m_pwm);
      end
    end
  endtask

  task automatic check_pwm(input string name, input int exp);
    checks++;
    if (bus.PWMin !== 18'(exp)) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, bus.PWMin, exp);
    end
  endtask

  task automatic test_reset();
    set_in(0, 0, 0, 0, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.ena2 !== 1'b0 || bus.busy !== 1'b0 || bus.PWMin !== 18'sd0) begin
      failures++;
      $display("FAIL reset_state got ena2=%0b busy=%0b pwm=%0d exp 0/0/0", bus.ena2, bus.busy, bus.PWMin);
    end
    model_clear();
    rst = 1'b1;
  endtask

  task automatic test_proportional();
    do_reset();
    set_in(128, -128, 1, 0, 0);
    repeat (3) begin
      wait_sample();
      check_pwm("p_only", 256);
    end
  endtask

  task automatic test_integral_sat();
    do_reset();
    set_in(255, -256, 0, 255, 0);
    wait_sample();
    check_pwm("integ_first", 130305);
    wait_sample();
    check_pwm("integ_sat", 131071);
    wait_sample();
    check_pwm("integ_sat_hold", 131071);
  endtask

  task automatic test_derivative();
    do_reset();
    set_in(0, 0, 0, 0, 1);
    wait_sample();
    check_pwm("d_zero", 0);
    bus.referencia = 9'sd128;
    bus.yactual    = -9'sd128;
    wait_sample();
    check_pwm("d_step", 256);
    wait_sample();
    check_pwm("d_settle", 0);
  endtask

  task automatic test_integ_clamp();
    do_reset();
    set_in(-256, 255, 0, 1, 0);
    repeat (70) wait_sample();
    check_pwm("integ_clamp", -32768);
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_in(100, 0, 1, 1, 1);
    wait_sample();
    wait_phase(2);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.ena2 !== 1'b0 || bus.busy !== 1'b0 || bus.PWMin !== 18'sd0) begin
      failures++;
      $display("FAIL mid_reset got ena2=%0b busy=%0b pwm=%0d exp 0/0/0", bus.ena2, bus.busy, bus.PWMin);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus.ena2 !== 1'b0) begin
        failures++;
        $display("FAIL mid_reset_ena2 got=%0b exp=0", bus.ena2);
      end
    end
    model_clear();
    rst = 1'b1;
    wait_sample();
    check_pwm("restart_de_eq_e", 300);
  endtask

  task automatic test_kp_latch();
    do_reset();
    set_in(100, 0, 1, 0, 0);
    wait_phase(1);
    bus.kp = 9'sd10;
    wait_sample();
    check_pwm("kp_latched", 100);
    wait_sample();
    check_pwm("kp_new", 1000);
  endtask

  task automatic test_random();
    do_reset();
    repeat (40) begin
      set_in(rnd9(), rnd9(), rnd9(), rnd9(), rnd9());
      wait_phase(2);
      set_in(rnd9(), rnd9(), rnd9(), rnd9(), rnd9());
      wait_sample();
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_proportional();
    test_integral_sat();
    test_derivative();
    test_integ_clamp();
    test_reset_mid();
    test_kp_latch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
